// File: rtl/jstk_spi_responder_pkg.sv
// Shared definitions for the joystick SPI responder: FSM encoding, frame geometry
// and the packing of the 40-bit response.
package jstk_spi_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } jstk_state_e;

  localparam int JSTK_FRAME_BYTES = 5;
  localparam int JSTK_DATA_W      = 10;
  localparam int JSTK_BTN_W       = 3;
  localparam int JSTK_RSP_W       = 40;
  localparam int JSTK_HI_PAD      = 6;   // zero bits above the 2 MSBs of x / y
  localparam int JSTK_BTN_PAD     = 5;   // zero bits above the button field

  // Byte order on MISO: x low, x high, y low, y high, buttons.
  function automatic logic [JSTK_RSP_W-1:0] jstk_pack_rsp(
    input logic [JSTK_DATA_W-1:0] x,
    input logic [JSTK_DATA_W-1:0] y,
    input logic [JSTK_BTN_W-1:0]  btn
  );
    return {x[7:0], {JSTK_HI_PAD{1'b0}}, x[9:8],
            y[7:0], {JSTK_HI_PAD{1'b0}}, y[9:8],
            {JSTK_BTN_PAD{1'b0}}, btn};
  endfunction

endpackage

// File: rtl/jstk_spi_responder_pin_sync.sv
// Synchronizes one asynchronous SPI pin into clk and flags any transition of the
// synchronized level (one extra register); latency STAGES cycles to level, +0 to edge.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic lvl_o,
  output logic edge_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign lvl_o  = sync_q[STAGES-1];
  assign edge_o = sync_q[STAGES-1] ^ prev_q;

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 responder returning a joystick snapshot and capturing the master's command byte.
// Optional frame counter enabled by defining JSTK_RSP_STATS_EN.
module jstk_spi_responder
  import jstk_spi_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BYTES = JSTK_FRAME_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   SCLK,
  input  logic                   MOSI,
  input  logic                   CS,
  output logic                   MISO,
  input  logic [JSTK_DATA_W-1:0] x_in,
  input  logic [JSTK_DATA_W-1:0] y_in,
  input  logic [JSTK_BTN_W-1:0]  btn_in,
  output logic [7:0]             cmd_byte,
  output logic                   cmd_valid,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic                   busy,
  output logic [15:0]            frame_count
);

  localparam int BCW = $clog2(FRAME_BYTES + 1);
  localparam logic [BCW-1:0] BYTES_END = BCW'(FRAME_BYTES);

  logic sclk_s, sclk_edge, mosi_s, mosi_edge_unused, cs_s, cs_edge;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .pin_i(SCLK), .lvl_o(sclk_s), .edge_o(sclk_edge)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .pin_i(MOSI), .lvl_o(mosi_s), .edge_o(mosi_edge_unused)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .pin_i(CS), .lvl_o(cs_s), .edge_o(cs_edge)
  );

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  assign sclk_rise = sclk_edge &  sclk_s;
  assign sclk_fall = sclk_edge & ~sclk_s;
  assign cs_rise   = cs_edge   &  cs_s;
  assign cs_fall   = cs_edge   & ~cs_s;

  jstk_state_e           state_q, state_d;
  logic [JSTK_RSP_W-1:0] rsp_q, rsp_d;
  logic                  miso_q, miso_d;
  logic [7:0]            rx_q, rx_d;
  logic [2:0]            bit_q, bit_d;
  logic [BCW-1:0]        byte_q, byte_d;
  logic [7:0]            cmd_q, cmd_d;
  logic                  cmd_vld_q, cmd_vld_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rsp_q     <= '0;
      miso_q    <= 1'b0;
      rx_q      <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      cmd_q     <= '0;
      cmd_vld_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_q     <= rsp_d;
      miso_q    <= miso_d;
      rx_q      <= rx_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      cmd_q     <= cmd_d;
      cmd_vld_q <= cmd_vld_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rsp_d     = rsp_q;
    miso_d    = miso_q;
    rx_d      = rx_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    cmd_d     = cmd_q;
    cmd_vld_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d = ST_LOAD;
          rx_d    = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      ST_LOAD: begin
        rsp_d  = jstk_pack_rsp(x_in, y_in, btn_in);
        miso_d = rsp_d[JSTK_RSP_W-1];
        if (cs_rise) begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
          err_d   = 1'b0 | 1'b1;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // CS release wins over any SCLK edge seen in the same cycle.
        if (cs_rise) begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
          if (byte_q == BYTES_END && bit_q == 3'd0) done_d = 1'b1;
          else                                      err_d  = 1'b1;
        end else if (byte_q == BYTES_END) begin
          miso_d = 1'b0;
        end else if (sclk_rise) begin
          rx_d  = {rx_q[6:0], mosi_s};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            byte_d = byte_q + BCW'(1);
            if (byte_q == '0) begin
              cmd_d     = rx_d;
              cmd_vld_d = 1'b1;
            end
          end
        end else if (sclk_fall) begin
          rsp_d  = {rsp_q[JSTK_RSP_W-2:0], 1'b0};
          miso_d = rsp_q[JSTK_RSP_W-2];
        end
      end
      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  assign MISO       = miso_q;
  assign cmd_byte   = cmd_q;
  assign cmd_valid  = cmd_vld_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef JSTK_RSP_STATS_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        frame_cnt_q <= '0;
    else if (done_q) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign frame_count = frame_cnt_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Randomized bench: SPI master model drives frames, a scoreboard checks the
// cmd_valid / frame_done / frame_err pulses and the bytes read back on MISO.
module tb_jstk_spi_responder;

  localparam int SYNC_STAGES = 2;
  localparam int FRAME_BYTES = 5;
  localparam int HALF        = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        CS = 1'b1;
  logic        MISO;
  logic [9:0]  x_in = '0;
  logic [9:0]  y_in = '0;
  logic [2:0]  btn_in = '0;
  logic [7:0]  cmd_byte;
  logic        cmd_valid, frame_done, frame_err, busy;
  logic [15:0] frame_count;

  jstk_spi_responder #(.SYNC_STAGES(SYNC_STAGES), .FRAME_BYTES(FRAME_BYTES)) dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .MOSI(MOSI), .CS(CS), .MISO(MISO),
    .x_in(x_in), .y_in(y_in), .btn_in(btn_in),
    .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .frame_done(frame_done),
    .frame_err(frame_err), .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  localparam int EV_CMD = 0, EV_DONE = 1, EV_ERR = 2;
  typedef struct { int kind; logic [7:0] val; } ev_t;
  ev_t exp_q[$];

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_cmd = '0;
  int         model_frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int kind, input logic [7:0] val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_pulse: got kind %0d val %0h expected none", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_CMD && e.val !== val)) begin
        errors++;
        $display("FAIL pulse_order: got kind %0d val %0h expected kind %0d val %0h",
                 kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor: every output pulse must match the next expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (cmd_valid)  sb_pop(EV_CMD, cmd_byte);
      if (frame_done) sb_pop(EV_DONE, 8'h00);
      if (frame_err)  sb_pop(EV_ERR, 8'h00);
    end
  end

  function automatic int exp_count();
`ifdef JSTK_RSP_STATS_EN
    return model_frames % 65536;
`else
    return 0;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int nbits, input logic [7:0] b0, input logic [9:0] x,
                           input logic [9:0] y, input logic [2:0] btn, input bit rst_abort);
    logic [7:0] exp_b[6];
    logic [7:0] mosi_b[6];
    logic [7:0] got;
    int         bi;
    exp_b[0] = 8'(x % 256);
    exp_b[1] = 8'(x / 256);
    exp_b[2] = 8'(y % 256);
    exp_b[3] = 8'(y / 256);
    exp_b[4] = 8'(btn);
    exp_b[5] = 8'h00;
    mosi_b[0] = b0;
    for (int k = 1; k < 6; k++) mosi_b[k] = 8'($urandom_range(0, 255));

    if (nbits >= 8) begin
      exp_q.push_back('{EV_CMD, b0});
      model_cmd = b0;
    end
    if (!rst_abort) begin
      if (nbits >= 8 * FRAME_BYTES) begin
        exp_q.push_back('{EV_DONE, 8'h00});
        model_frames++;
      end else begin
        exp_q.push_back('{EV_ERR, 8'h00});
      end
    end

    x_in = x; y_in = y; btn_in = btn;
    CS = 1'b0;
    tick(SYNC_STAGES + 2);
    check("miso_first_bit", MISO, exp_b[0][7]);
    check("busy_in_frame", busy, 1);
    // Inputs move after the snapshot; the response must not follow them.
    x_in = 10'($urandom_range(0, 1023));
    y_in = 10'($urandom_range(0, 1023));
    btn_in = 3'($urandom_range(0, 7));

    got = '0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mosi_b[i / 8][7 - (i % 8)];
      tick(HALF);
      got = {got[6:0], MISO};
      SCLK = 1'b1;
      tick(HALF);
      SCLK = 1'b0;
      if (i % 8 == 7) begin
        bi = i / 8;
        check($sformatf("miso_byte%0d", bi), got, (bi < FRAME_BYTES) ? exp_b[bi] : 8'h00);
      end
    end
    tick(HALF);

    if (rst_abort) begin
      rst = 1'b0;
      CS = 1'b1;
      tick(4);
      check("rst_miso", MISO, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_byte", cmd_byte, 0);
      check("rst_frame_count", frame_count, 0);
      rst = 1'b1;
      model_cmd = '0;
      model_frames = 0;
      tick(HALF);
    end else begin
      CS = 1'b1;
      tick(SYNC_STAGES + 2);
      check("busy_after_cs", busy, 0);
      check("miso_idle", MISO, 0);
      check("cmd_byte_hold", cmd_byte, model_cmd);
      tick(HALF);
      check("frame_count", frame_count, exp_count());
    end
  endtask

  initial begin
    int nb;
    tick(3);
    check("reset_miso", MISO, 0);
    check("reset_busy", busy, 0);
    check("reset_cmd_byte", cmd_byte, 0);
    check("reset_cmd_valid", cmd_valid, 0);
    check("reset_done", frame_done, 0);
    check("reset_err", frame_err, 0);
    check("reset_frame_count", frame_count, 0);
    rst = 1'b1;
    tick(4);

    run_frame(40, 8'h84, 10'h2A5, 10'h13C, 3'b101, 1'b0);
    run_frame(12, 8'h84, 10'h2A5, 10'h13C, 3'b101, 1'b0);
    run_frame(48, 8'($urandom_range(0, 255)), 10'($urandom_range(0, 1023)),
              10'($urandom_range(0, 1023)), 3'($urandom_range(0, 7)), 1'b0);
    run_frame(20, 8'($urandom_range(0, 255)), 10'($urandom_range(0, 1023)),
              10'($urandom_range(0, 1023)), 3'($urandom_range(0, 7)), 1'b1);
    run_frame(40, 8'($urandom_range(0, 255)), 10'h2A5, 10'h13C, 3'b101, 1'b0);

    for (int f = 0; f < 10; f++) begin
      case ($urandom_range(0, 3))
        0, 1:    nb = 40;
        2:       nb = 48;
        default: nb = $urandom_range(1, 39);
      endcase
      run_frame(nb, 8'($urandom_range(0, 255)), 10'($urandom_range(0, 1023)),
                10'($urandom_range(0, 1023)), 3'($urandom_range(0, 7)), 1'b0);
    end

    tick(20);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jstk_spi_responder.md
JSTK_SPI_RESPONDER -- requirements
Module: jstk_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for SCLK, MOSI and CS (minimum 2).
REQ-002 SHALL have parameter FRAME_BYTES, default 5: number of response bytes per frame.
REQ-003 SHALL have ports, clock and reset first:
- clk  input  1  system clock; the only clock; at least 8x the SCLK frequency.
- rst  input  1  asynchronous, active-low reset.
- SCLK  input  1  SPI clock from the master, mode 0.
- MOSI  input  1  master data, MSB first.
- CS  input  1  chip select, active-low.
- MISO  output  1  responder data, MSB first.
- x_in  input  10  joystick X value.
- y_in  input  10  joystick Y value.
- btn_in  input  3  buttons {trigger, jstk, btn}.
- cmd_byte  output  8  first MOSI byte of the last frame.
- cmd_valid  output  1  one-cycle pulse when cmd_byte updates.
- frame_done  output  1  one-cycle pulse on a complete frame.
- frame_err  output  1  one-cycle pulse on an aborted frame.
- busy  output  1  high while a frame is active.
- frame_count  output  16  count of completed frames (see Configuration).

Function
REQ-004 SHALL pass SCLK, MOSI and CS through SYNC_STAGES flops each, then detect edges with one extra register; all logic SHALL use only the synchronized signals.
REQ-005 SHALL implement the FSM IDLE -> LOAD -> SHIFT -> IDLE.
- IDLE -> LOAD on a synced CS falling edge.
- LOAD -> SHIFT after one cycle.
- SHIFT -> IDLE on a synced CS rising edge.
REQ-006 LOAD SHALL snapshot x_in, y_in and btn_in into a 40-bit response register: {x[7:0], 6'b0,x[9:8], y[7:0], 6'b0,y[9:8], 5'b0,btn}. Inputs SHALL NOT be sampled again during the frame.
REQ-007 MISO SHALL present response bit 39 by the end of LOAD, i.e. within SYNC_STAGES+2 clk cycles of CS falling at the pin.
REQ-008 In SHIFT:
- each synced SCLK rising edge SHALL shift the synced MOSI into an 8-bit receive register and increment a 3-bit bit counter;
- each synced SCLK falling edge SHALL advance MISO to the next response bit.
REQ-009 When the bit counter wraps 7->0, the byte counter SHALL increment. After byte 0 completes, cmd_byte SHALL load the receive register and cmd_valid SHALL pulse for exactly one cycle.
REQ-010 After FRAME_BYTES bytes, MISO SHALL output 0. Further SCLK edges SHALL be ignored, except that the byte counter saturates at FRAME_BYTES.
REQ-011 On a CS rising edge:
- byte counter == FRAME_BYTES and bit counter == 0: frame_done SHALL pulse;
- otherwise (mid-frame): frame_err SHALL pulse, cmd_byte SHALL be retained if it was already updated, and no frame_done SHALL be issued.
REQ-012 A CS rising edge and an SCLK edge in the same cycle: the CS rising edge SHALL take priority and the SCLK edge SHALL be dropped.
REQ-013 MISO SHALL be 0 whenever the state is IDLE.
REQ-014 busy SHALL be high in LOAD and SHIFT.

Reset
REQ-015 Asserting rst SHALL asynchronously force:
- state to IDLE;
- MISO, cmd_valid, frame_done, frame_err and busy to 0;
- cmd_byte, frame_count, all counters and all synchronizer flops to 0 (synchronizer CS flops to 1).
REQ-016 Reset asserted mid-frame SHALL abort silently, with no frame_err. After release, a new frame SHALL require a fresh CS falling edge.

Configuration
REQ-017 With JSTK_RSP_STATS_EN defined, frame_count SHALL increment, wrapping at 16 bits, on every frame_done pulse.
REQ-018 Without JSTK_RSP_STATS_EN, frame_count SHALL be constant 0 and its counter logic SHALL NOT be synthesized.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding, JSTK_FRAME_BYTES = 5, JSTK_DATA_W = 10 and the response-byte layout constants.
REQ-020 The synchronizer and edge detector SHALL be a single sub-module, spi_pin_sync, instantiated three times.

Verification
REQ-021 Normal frame: x_in=10'h2A5, y_in=10'h13C, btn_in=3'b101, 40 SCLK at clk/16, MOSI byte0=8'h84 -> MISO bytes A5,02,3C,01,05; cmd_byte=84 with one cmd_valid pulse; one frame_done.
REQ-022 Snapshot: x_in changed to 10'h000 after CS falls -> MISO still carries A5,02.
REQ-023 Abort: CS raised after 12 bits -> one frame_err, no frame_done, cmd_byte=84, busy=0 within SYNC_STAGES+2 cycles.
REQ-024 Overrun: 48 SCLK cycles -> last 8 MISO bits 0, exactly one frame_done at CS rise.
REQ-025 Reset mid-frame after 20 bits, then a clean frame -> no pulses during reset, and a correct response on the next frame.
REQ-026 Counter with JSTK_RSP_STATS_EN: 3 complete frames plus 1 aborted frame -> frame_count=3; without the macro frame_count stays 0.
